// File: rtl/control_unit.sv
// Multicycle MIPS-subset control FSM: fetch/decode/execute/writeback with registered Moore outputs.
// Optional macro SHIFT_INSTR_EN enables sll/srl/sra (R funct 0x00/0x02/0x03); otherwise those decode as invalid.
module control_unit #(
  parameter int MEM_WAIT = 1,
  parameter int SP_INIT  = 227
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OPCODE,
  input  logic [5:0] FUNCT,
  input  logic       O,
  input  logic       Z,
  input  logic       LT,
  output logic       PC_w,
  output logic       MEM_w,
  output logic       IR_w,
  output logic       BR_w,
  output logic       AB_w,
  output logic       EPC_w,
  output logic       HI_w,
  output logic       LO_w,
  output logic       MDR_w,
  output logic       ALUOut_w,
  output logic [2:0] ALU_op,
  output logic [2:0] Shift_op,
  output logic [1:0] M_SrcA,
  output logic [1:0] M_SrcB,
  output logic [1:0] M_IorD,
  output logic [1:0] M_EXCEPTION,
  output logic [1:0] M_WRITE_REG,
  output logic [2:0] M_WRITE_DATA,
  output logic [1:0] M_PCSource,
  output logic [5:0] state
);

  typedef enum logic [5:0] {
    S_RESET    = 6'd0,  S_SETSP    = 6'd1,  S_FETCH    = 6'd2,  S_FETCH_LD = 6'd3,
    S_DECODE   = 6'd4,  S_R_ALU    = 6'd5,  S_R_WB     = 6'd6,  S_SLT      = 6'd7,
    S_ADDI     = 6'd8,  S_ADDI_WB  = 6'd9,  S_MEM_ADDR = 6'd10, S_LW_WAIT  = 6'd11,
    S_LW_MDR   = 6'd12, S_LW_WB    = 6'd13, S_SW       = 6'd14, S_BEQ      = 6'd15,
    S_BEQ_TAKE = 6'd16, S_JUMP     = 6'd17, S_JAL_SAVE = 6'd18, S_JAL_WR   = 6'd19,
    S_SH_LOAD  = 6'd20, S_SH_DO    = 6'd21, S_SH_WB    = 6'd22, S_INVOP    = 6'd23,
    S_OVF      = 6'd24, S_EXC_RD   = 6'd25, S_EXC_MDR  = 6'd26, S_EXC_PC   = 6'd27
  } state_t;

  typedef struct packed {
    logic       pc_w, mem_w, ir_w, br_w, ab_w, epc_w, hi_w, lo_w, mdr_w, aluout_w;
    logic [2:0] alu_op;
    logic [2:0] shift_op;
    logic [1:0] src_a, src_b, iord, exc, wreg;
    logic [2:0] wdata;
    logic [1:0] pcsrc;
  } ctl_t;

  localparam logic [1:0] WAIT_LAST = 2'(MEM_WAIT - 1);

  state_t     state_q, nxt, dec;
  ctl_t       ctl;
  logic [1:0] cnt;
  logic       exc_ovf;

  // LT is folded into the SLT bit by the datapath; SP_INIT is the constant behind write-data select 110.
  logic unused_ok;
  assign unused_ok = ^{LT, 32'(SP_INIT)};

  // Control word for a state; outputs are registered from the state being entered.
  function automatic ctl_t ctl_for(input state_t s, input logic [5:0] f, input logic ovf);
    ctl_t c;
    c = '0;
    case (s)
      S_SETSP:    begin c.br_w = 1'b1; c.wreg = 2'b11; c.wdata = 3'b110; end
      S_FETCH:    begin c.src_b = 2'b01; c.alu_op = 3'b001; end
      S_FETCH_LD: begin c.src_b = 2'b01; c.alu_op = 3'b001; c.ir_w = 1'b1; c.pc_w = 1'b1; end
      S_DECODE:   begin c.ab_w = 1'b1; c.aluout_w = 1'b1; c.src_b = 2'b11; c.alu_op = 3'b001; end
      S_R_ALU: begin
        c.aluout_w = 1'b1; c.src_a = 2'b01;
        c.alu_op   = (f == 6'h22) ? 3'b010 : (f == 6'h24) ? 3'b011 : 3'b001;
      end
      S_R_WB:     begin c.br_w = 1'b1; c.wreg = 2'b01; c.wdata = 3'b001; end
      S_SLT: begin
        c.alu_op = 3'b111; c.src_a = 2'b01;
        c.br_w = 1'b1; c.wreg = 2'b01; c.wdata = 3'b101;
      end
      S_ADDI, S_MEM_ADDR: begin
        c.aluout_w = 1'b1; c.src_a = 2'b01; c.src_b = 2'b10; c.alu_op = 3'b001;
      end
      S_ADDI_WB:  begin c.br_w = 1'b1; c.wdata = 3'b001; end
      S_LW_WAIT:  c.iord = 2'b01;
      S_LW_MDR:   begin c.mdr_w = 1'b1; c.iord = 2'b01; end
      S_LW_WB:    c.br_w = 1'b1;
      S_SW:       begin c.mem_w = 1'b1; c.iord = 2'b01; end
      S_BEQ:      begin c.src_a = 2'b01; c.alu_op = 3'b010; end
      S_BEQ_TAKE: begin c.pc_w = 1'b1; c.pcsrc = 2'b01; end
      S_JUMP:     begin c.pc_w = 1'b1; c.pcsrc = 2'b10; end
      S_JAL_SAVE: c.aluout_w = 1'b1;
      S_JAL_WR:   begin c.br_w = 1'b1; c.wreg = 2'b10; c.wdata = 3'b001; end
      S_SH_LOAD:  c.shift_op = 3'b001;
      S_SH_DO:    c.shift_op = (f == 6'h00) ? 3'b010 : (f == 6'h02) ? 3'b011 : 3'b100;
      S_SH_WB:    begin c.br_w = 1'b1; c.wreg = 2'b01; c.wdata = 3'b100; end
      S_INVOP, S_OVF: begin
        c.epc_w = 1'b1; c.src_b = 2'b01; c.alu_op = 3'b010;
        c.exc   = (s == S_OVF) ? 2'b01 : 2'b00;
      end
      S_EXC_RD:   begin c.iord = 2'b10; c.exc = {1'b0, ovf}; end
      S_EXC_MDR:  begin c.mdr_w = 1'b1; c.iord = 2'b10; c.exc = {1'b0, ovf}; end
      S_EXC_PC:   begin c.pc_w = 1'b1; c.pcsrc = 2'b11; c.exc = {1'b0, ovf}; end
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    dec = S_INVOP;
    case (OPCODE)
      6'h00: begin
        case (FUNCT)
          6'h20, 6'h22, 6'h24: dec = S_R_ALU;
          6'h2A:               dec = S_SLT;
`ifdef SHIFT_INSTR_EN
          6'h00, 6'h02, 6'h03: dec = S_SH_LOAD;
`else
          6'h00:               dec = S_FETCH;
`endif
          default: ;
        endcase
      end
      6'h08:        dec = S_ADDI;
      6'h23, 6'h2B: dec = S_MEM_ADDR;
      6'h04:        dec = S_BEQ;
      6'h02:        dec = S_JUMP;
      6'h03:        dec = S_JAL_SAVE;
      default: ;
    endcase
  end

  always_comb begin
    nxt = state_q;
    case (state_q)
      S_RESET:    nxt = S_SETSP;
      S_FETCH:    if (cnt == WAIT_LAST) nxt = S_FETCH_LD;
      S_FETCH_LD: nxt = S_DECODE;
      S_DECODE:   nxt = dec;
      S_R_ALU:    nxt = (O && FUNCT != 6'h24) ? S_OVF : S_R_WB;
      S_ADDI:     nxt = O ? S_OVF : S_ADDI_WB;
      S_MEM_ADDR: nxt = (OPCODE == 6'h23) ? S_LW_WAIT : S_SW;
      S_LW_WAIT:  if (cnt == WAIT_LAST) nxt = S_LW_MDR;
      S_LW_MDR:   nxt = S_LW_WB;
      S_BEQ:      nxt = Z ? S_BEQ_TAKE : S_FETCH;
      S_JAL_SAVE: nxt = S_JAL_WR;
      S_JAL_WR:   nxt = S_JUMP;
      S_SH_LOAD:  nxt = S_SH_DO;
      S_SH_DO:    nxt = S_SH_WB;
      S_INVOP, S_OVF: nxt = S_EXC_RD;
      S_EXC_RD:   if (cnt == WAIT_LAST) nxt = S_EXC_MDR;
      S_EXC_MDR:  nxt = S_EXC_PC;
      default:    nxt = S_FETCH;
    endcase
  end

  // Only the wait states self-loop, so any state change restarts the wait count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RESET;
      ctl     <= '0;
      cnt     <= 2'd0;
      exc_ovf <= 1'b0;
    end else begin
      state_q <= nxt;
      ctl     <= ctl_for(nxt, FUNCT, exc_ovf);
      cnt     <= (nxt == state_q) ? cnt + 2'd1 : 2'd0;
      if (nxt == S_OVF)        exc_ovf <= 1'b1;
      else if (nxt == S_INVOP) exc_ovf <= 1'b0;
    end
  end

  assign PC_w         = ctl.pc_w;
  assign MEM_w        = ctl.mem_w;
  assign IR_w         = ctl.ir_w;
  assign BR_w         = ctl.br_w;
  assign AB_w         = ctl.ab_w;
  assign EPC_w        = ctl.epc_w;
  assign HI_w         = ctl.hi_w;
  assign LO_w         = ctl.lo_w;
  assign MDR_w        = ctl.mdr_w;
  assign ALUOut_w     = ctl.aluout_w;
  assign ALU_op       = ctl.alu_op;
  assign Shift_op     = ctl.shift_op;
  assign M_SrcA       = ctl.src_a;
  assign M_SrcB       = ctl.src_b;
  assign M_IorD       = ctl.iord;
  assign M_EXCEPTION  = ctl.exc;
  assign M_WRITE_REG  = ctl.wreg;
  assign M_WRITE_DATA = ctl.wdata;
  assign M_PCSource   = ctl.pcsrc;
  assign state        = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-instruction expected output traces built from the instruction rules.
module tb_control_unit;
  localparam int MW = 2;

  logic       clk, reset, O, Z, LT;
  logic [5:0] OPCODE, FUNCT;
  logic       PC_w, MEM_w, IR_w, BR_w, AB_w, EPC_w, HI_w, LO_w, MDR_w, ALUOut_w;
  logic [2:0] ALU_op, Shift_op, M_WRITE_DATA;
  logic [1:0] M_SrcA, M_SrcB, M_IorD, M_EXCEPTION, M_WRITE_REG, M_PCSource;
  logic [5:0] state;

  control_unit #(.MEM_WAIT(MW), .SP_INIT(227)) dut (
    .clk(clk), .reset(reset), .OPCODE(OPCODE), .FUNCT(FUNCT), .O(O), .Z(Z), .LT(LT),
    .PC_w(PC_w), .MEM_w(MEM_w), .IR_w(IR_w), .BR_w(BR_w), .AB_w(AB_w), .EPC_w(EPC_w),
    .HI_w(HI_w), .LO_w(LO_w), .MDR_w(MDR_w), .ALUOut_w(ALUOut_w), .ALU_op(ALU_op),
    .Shift_op(Shift_op), .M_SrcA(M_SrcA), .M_SrcB(M_SrcB), .M_IorD(M_IorD),
    .M_EXCEPTION(M_EXCEPTION), .M_WRITE_REG(M_WRITE_REG), .M_WRITE_DATA(M_WRITE_DATA),
    .M_PCSource(M_PCSource), .state(state)
  );

  typedef struct packed {
    logic       pc_w, mem_w, ir_w, br_w, ab_w, epc_w, hi_w, lo_w, mdr_w, aluout_w;
    logic [2:0] alu_op;
    logic [2:0] shift_op;
    logic [1:0] src_a, src_b, iord, exc, wreg;
    logic [2:0] wdata;
    logic [1:0] pcsrc;
  } exp_t;

  logic [30:0] act;
  assign act = {PC_w, MEM_w, IR_w, BR_w, AB_w, EPC_w, HI_w, LO_w, MDR_w, ALUOut_w,
                ALU_op, Shift_op, M_SrcA, M_SrcB, M_IorD, M_EXCEPTION, M_WRITE_REG,
                M_WRITE_DATA, M_PCSource};

  exp_t  expq[$];
  exp_t  cur;
  int    checks = 0;
  int    passed = 0;
  int    cur_len = 0;
  string cur_name = "reset";
  logic  cmp_en = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a === x) passed++;
    else $display("FAIL %s: got %h, expected %h", nm, a, x);
  endtask

  // Single compare process: one expected record per cycle while a trace is pending.
  always @(negedge clk) begin
    if (cmp_en && expq.size() != 0) begin
      cur = expq.pop_front();
      chk($sformatf("%s cycle %0d", cur_name, cur_len - expq.size() - 1), 32'(act), 32'(cur));
    end
  end

  task automatic put(input exp_t e);
    expq.push_back(e);
  endtask

  task automatic wb(input logic [1:0] r, input logic [2:0] d);
    exp_t e;
    e = '0; e.br_w = 1'b1; e.wreg = r; e.wdata = d; put(e);
  endtask

  task automatic fetch_dec();
    exp_t e;
    for (int i = 0; i < MW; i++) begin
      e = '0; e.src_b = 2'b01; e.alu_op = 3'b001; put(e);
    end
    e = '0; e.src_b = 2'b01; e.alu_op = 3'b001; e.ir_w = 1'b1; e.pc_w = 1'b1; put(e);
    e = '0; e.ab_w = 1'b1; e.aluout_w = 1'b1; e.src_b = 2'b11; e.alu_op = 3'b001; put(e);
  endtask

  task automatic exc_seq(input logic ovf);
    exp_t e;
    e = '0; e.epc_w = 1'b1; e.src_b = 2'b01; e.alu_op = 3'b010; e.exc = {1'b0, ovf}; put(e);
    for (int i = 0; i < MW; i++) begin
      e = '0; e.iord = 2'b10; e.exc = {1'b0, ovf}; put(e);
    end
    e = '0; e.mdr_w = 1'b1; e.iord = 2'b10; e.exc = {1'b0, ovf}; put(e);
    e = '0; e.pc_w = 1'b1; e.pcsrc = 2'b11; e.exc = {1'b0, ovf}; put(e);
  endtask

  task automatic addr_calc();
    exp_t e;
    e = '0; e.aluout_w = 1'b1; e.src_a = 2'b01; e.src_b = 2'b10; e.alu_op = 3'b001; put(e);
  endtask

  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic o, input logic zf);
    exp_t e;
    fetch_dec();
    if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24)) begin
      e = '0; e.aluout_w = 1'b1; e.src_a = 2'b01;
      e.alu_op = (fn == 6'h20) ? 3'b001 : (fn == 6'h22) ? 3'b010 : 3'b011;
      put(e);
      if (o && fn != 6'h24) exc_seq(1'b1);
      else wb(2'b01, 3'b001);
    end else if (op == 6'h00 && fn == 6'h2A) begin
      e = '0; e.alu_op = 3'b111; e.src_a = 2'b01;
      e.br_w = 1'b1; e.wreg = 2'b01; e.wdata = 3'b101; put(e);
    end
`ifdef SHIFT_INSTR_EN
    else if (op == 6'h00 && (fn == 6'h00 || fn == 6'h02 || fn == 6'h03)) begin
      e = '0; e.shift_op = 3'b001; put(e);
      e = '0; e.shift_op = (fn == 6'h00) ? 3'b010 : (fn == 6'h02) ? 3'b011 : 3'b100; put(e);
      wb(2'b01, 3'b100);
    end
`else
    else if (op == 6'h00 && fn == 6'h00) begin
    end
`endif
    else if (op == 6'h08) begin
      addr_calc();
      if (o) exc_seq(1'b1);
      else wb(2'b00, 3'b001);
    end else if (op == 6'h23) begin
      addr_calc();
      for (int i = 0; i < MW; i++) begin
        e = '0; e.iord = 2'b01; put(e);
      end
      e = '0; e.mdr_w = 1'b1; e.iord = 2'b01; put(e);
      wb(2'b00, 3'b000);
    end else if (op == 6'h2B) begin
      addr_calc();
      e = '0; e.mem_w = 1'b1; e.iord = 2'b01; put(e);
    end else if (op == 6'h04) begin
      e = '0; e.src_a = 2'b01; e.alu_op = 3'b010; put(e);
      if (zf) begin
        e = '0; e.pc_w = 1'b1; e.pcsrc = 2'b01; put(e);
      end
    end else if (op == 6'h02 || op == 6'h03) begin
      if (op == 6'h03) begin
        e = '0; e.aluout_w = 1'b1; put(e);
        wb(2'b10, 3'b001);
      end
      e = '0; e.pc_w = 1'b1; e.pcsrc = 2'b10; put(e);
    end else begin
      exc_seq(1'b0);
    end
  endtask

  // Returns just after the posedge on which the DUT leaves the previous trace.
  task automatic drain();
    int g = 0;
    while (expq.size() != 0 && g < 200) begin
      @(posedge clk);
      g++;
    end
    if (expq.size() != 0) begin
      checks++;
      $display("FAIL drain %s: %0d records pending, expected 0", cur_name, expq.size());
      expq.delete();
    end
  endtask

  task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic o,
                     input logic zf, input string nm);
    drain();
    #1;
    OPCODE = op; FUNCT = fn; O = o; Z = zf; cur_name = nm;
    build(op, fn, o, zf);
    cur_len = expq.size();
  endtask

  task automatic push_sp(input string nm);
    exp_t e;
    e = '0; e.br_w = 1'b1; e.wreg = 2'b11; e.wdata = 3'b110; put(e);
    cur_len = 1; cur_name = nm;
  endtask

  initial begin
    reset = 1'b1; OPCODE = 6'h00; FUNCT = 6'h00; O = 1'b0; Z = 1'b0; LT = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("reset outputs", 32'(act), 32'd0);
    reset = 1'b0;
    #1;
    push_sp("sp init");
    cmp_en = 1'b1;
    @(posedge clk); #1;
    chk("sp init literal", 32'({BR_w, M_WRITE_REG, M_WRITE_DATA}), 32'h3E);

    run(6'h00, 6'h20, 1'b0, 1'b0, "add");
    chk("add trace length", 32'(cur_len), 32'd6);
    run(6'h00, 6'h22, 1'b0, 1'b0, "sub");
    run(6'h00, 6'h24, 1'b1, 1'b0, "and O=1");
    run(6'h00, 6'h20, 1'b1, 1'b0, "add overflow");
    run(6'h00, 6'h2A, 1'b0, 1'b0, "slt");
    run(6'h08, 6'h15, 1'b0, 1'b0, "addi");
    run(6'h08, 6'h15, 1'b1, 1'b0, "addi overflow");
    chk("addi ovf trace length", 32'(cur_len), 32'd10);
    run(6'h23, 6'h04, 1'b0, 1'b0, "lw");
    chk("lw trace length", 32'(cur_len), 32'd9);
    run(6'h2B, 6'h08, 1'b0, 1'b0, "sw");
    run(6'h04, 6'h10, 1'b0, 1'b1, "beq taken");
    run(6'h04, 6'h10, 1'b0, 1'b0, "beq not taken");
    chk("beq nt trace length", 32'(cur_len), 32'd5);
    run(6'h02, 6'h00, 1'b0, 1'b0, "j");
    run(6'h03, 6'h00, 1'b0, 1'b0, "jal");
    chk("jal trace length", 32'(cur_len), 32'd7);
    run(6'h3F, 6'h3F, 1'b0, 1'b0, "invalid opcode");
    run(6'h00, 6'h02, 1'b0, 1'b0, "funct 0x02");
    run(6'h00, 6'h00, 1'b0, 1'b0, "all-zero IR");
    run(6'h00, 6'h03, 1'b0, 1'b0, "funct 0x03");
    run(6'h00, 6'h11, 1'b0, 1'b0, "bad funct");

    run(6'h00, 6'h20, 1'b0, 1'b0, "add before reset");
    @(negedge clk); #2;
    cmp_en = 1'b0;
    expq.delete();
    reset = 1'b1;
    #1;
    chk("async reset outputs", 32'(act), 32'd0);
    @(negedge clk);
    chk("held reset outputs", 32'(act), 32'd0);
    reset = 1'b0;
    #1;
    push_sp("sp init after reset");
    cmp_en = 1'b1;
    run(6'h00, 6'h22, 1'b0, 1'b0, "sub after reset");
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
Multicycle control FSM for the MIPS-subset datapath. Consumes IR opcode/funct and ALU flags; produces every register write enable, mux select and ALU/shifter op for the datapath. Registered Moore outputs; one instruction runs fetch → decode → execute → writeback over 3–8 cycles.

Parameters:
MEM_WAIT, 1, wait cycles between a memory address being presented and its read data being valid (1..3).
SP_INIT, 227, value written to register 29 in the RESET state.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; forces RESET state
OPCODE  input  6  IR[31:26]
FUNCT  input  6  IR[5:0]
O, Z, LT  input  1 each  ALU overflow, zero, less-than
PC_w, MEM_w, IR_w, BR_w, AB_w, EPC_w, HI_w, LO_w, MDR_w, ALUOut_w  output  1 each  write enables
ALU_op  output  3  000 load A, 001 add, 010 sub, 011 and, 111 compare
Shift_op  output  3  000 nop, 001 load, 010 sll, 011 srl, 100 sra
M_SrcA  output  2  00 PC, 01 A
M_SrcB  output  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
M_IorD  output  2  00 PC, 01 ALUOut, 10 exception vector
M_EXCEPTION  output  2  00 vector 253 (invalid opcode), 01 vector 254 (overflow)
M_WRITE_REG  output  2  00 RT, 01 RD, 10 reg 31, 11 reg 29
M_WRITE_DATA  output  3  000 MDR, 001 ALUOut, 011 LO, 100 shifter, 101 SLT bit, 110 SP_INIT
M_PCSource  output  2  00 ALU result, 01 ALUOut, 10 jump target, 11 zero-extended MDR byte
state  output  6  current state code, for the debug bench

Behaviour:
- Reset (async): state=RESET; all enables 0, all selects 0. Next edge: BR_w=1, M_WRITE_REG=11, M_WRITE_DATA=110 (r29<=SP_INIT); then FETCH.
- Never assert reset-released enables combinationally; outputs change only on clk edges or async reset.
- FETCH: M_IorD=00, MEM_w=0; ALU PC+4 (SrcA=00, SrcB=01, op 001). A wait counter runs MEM_WAIT cycles, then one cycle with IR_w=1, PC_w=1, M_PCSource=00. Counter clears on every FETCH entry.
- DECODE (1 cycle): AB_w=1; ALUOut_w=1 with PC + imm<<2 (branch target).
- Dispatch on OPCODE (and FUNCT when OPCODE=0):
  R add/sub/and (0x20/0x22/0x24): ALUOut<=A op B; then BR_w, RD, data 001. add/sub with O=1 → OVF instead of writeback.
  R slt (0x2A): ALU op 111, BR_w, RD, data 101.
  addi (0x08): ALUOut<=A+imm; O=1 → OVF; else write RT.
  lw (0x23): ALUOut<=A+imm; read M_IorD=01 with MEM_WAIT wait; MDR_w; write RT, data 000.
  sw (0x2B): ALUOut<=A+imm; MEM_w=1 one cycle, M_IorD=01.
  beq (0x04): ALU sub A,B; if Z: PC_w, M_PCSource=01.
  j (0x02): PC_w, M_PCSource=10.
  jal (0x03): write reg 31 (data 001 holding PC) then as j.
  Anything else → INVOP.
- Every execution path ends in FETCH. No enable remains high more than one cycle except during wait counts.
- Exceptions (INVOP, OVF): EPC_w with ALU PC−4 (SrcA=00, SrcB=01, op 010); read vector (M_IorD=10, M_EXCEPTION 00/01) with MEM_WAIT wait; MDR_w; PC_w with M_PCSource=11; → FETCH.
- BR_w never asserted targeting reg 0 is not filtered here (register bank ignores r0).
- Reset mid-instruction: immediate abandon, no partial writes on the following edge.

Optional Feature:
SHIFT_INSTR_EN: defined → R funct 0x00/0x02/0x03 execute: Shift_op=001 (load B), shift by shamt (010/011/100), writeback RD with data 100; 3 cycles after DECODE. Undefined → those functs go to INVOP (except all-zero IR, which is treated as nop and returns to FETCH).

Test Plan:
- Reset pulse mid-FETCH → state=RESET asynchronously; next edge BR_w=1, M_WRITE_REG=11, M_WRITE_DATA=110; then FETCH.
- OPCODE=0, FUNCT=0x20, O=0 → ALUOut_w, then BR_w with M_WRITE_REG=01, M_WRITE_DATA=001; back to FETCH.
- lw with MEM_WAIT=2 → exactly 2 wait cycles between M_IorD=01 and MDR_w=1; then BR_w with RT.
- beq with Z=1 → PC_w, M_PCSource=01; with Z=0 → no PC_w, return to FETCH.
- addi with O=1 → EPC_w, M_IorD=10, M_EXCEPTION=01; PC_w with M_PCSource=11; no BR_w.
- OPCODE=0x3F → M_EXCEPTION=00 path; FUNCT=0x02 under each SHIFT_INSTR_EN setting → shift writeback vs INVOP.
